// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg -- shared encodings for the sequential shift-add multiplier.
//   MODE_*  : operand signedness selector carried on the 2-bit mode input.
//             Code 2'b11 is not listed and is treated as MODE_UU by the datapath.
//   state_t : controller states IDLE -> RUN -> DONE -> OUT -> IDLE.
package seq_mul_pkg;

  localparam logic [1:0] MODE_UU = 2'b00;  // unsigned a x unsigned b
  localparam logic [1:0] MODE_SS = 2'b01;  // signed a x signed b
  localparam logic [1:0] MODE_SU = 2'b10;  // signed a x unsigned b

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10,
    ST_OUT  = 2'b11
  } state_t;

endpackage

// File: rtl/seq_muln.sv
// seq_muln -- sequential shift-add multiplier with optional early termination.
//
// The operands are converted to sign/magnitude at capture. An unsigned magnitude
// product is accumulated one multiplier bit per RUN cycle. The result is
// re-signed once, in DONE.
//
// Parameters
//   WIDTH      operand width (4..64)
//   EARLY_TERM 1: stop once the remaining multiplier bits are all zero
//              0: always run WIDTH steps
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      synchronous active-high reset, overrides every other input
//   in_valid   operand request, accepted only while in_ready is high
//   in_ready   high only in IDLE
//   mode       00 UU, 01 SS, 10 SU, 11 behaves as 00
//   op_a       multiplicand
//   op_b       multiplier
//   out_valid  product valid, held until out_ready
//   out_ready  consumer accepts the product
//   product    2*WIDTH result, retained after handoff until the next DONE
//   busy       high in RUN, DONE and OUT
module seq_muln
  import seq_mul_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int EARLY_TERM = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  // Magnitude of a value that may be signed. The most-negative input maps to
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                               input logic is_signed);
    logic [WIDTH-1:0] r;
    if (is_signed && v[WIDTH-1]) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Two's-complement negate at product width.
  function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t               state_r;
  state_t               state_n;
  logic                 in_ready_r;
  logic                 busy_r;
  logic                 out_valid_r;
  logic [2*WIDTH-1:0]   product_r;
  logic [2*WIDTH-1:0]   p_r;       // magnitude accumulator
  logic [2*WIDTH-1:0]   mc_r;      // shifted multiplicand magnitude
  logic [WIDTH-1:0]     r_r;       // remaining multiplier magnitude bits
  logic [CNT_W-1:0]     cnt_r;
  logic                 neg_r;

  logic                 a_signed_s;
  logic                 b_signed_s;
  logic                 neg_s;
  logic [WIDTH-1:0]     abs_a_s;
  logic [WIDTH-1:0]     abs_b_s;
  logic                 run_last_s;

  // Operand decode at the capture boundary; mode 11 falls into the unsigned case.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (mode)
      MODE_SS: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      MODE_SU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    abs_a_s = abs_val(op_a, a_signed_s);
    abs_b_s = abs_val(op_b, b_signed_s);
    neg_s   = (a_signed_s & op_a[WIDTH-1]) ^ (b_signed_s & op_b[WIDTH-1]);
  end

  // Last RUN step: the counter has reached WIDTH-1, or (early termination)
  // no set multiplier bits remain above the one consumed this cycle.
  always_comb begin
    run_last_s = 1'b0;
    if (cnt_r == LAST_STEP) begin
      run_last_s = 1'b1;
    end else if ((EARLY_TERM != 0) && (r_r[WIDTH-1:1] == {(WIDTH-1){1'b0}})) begin
      run_last_s = 1'b1;
    end else begin
      run_last_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_n = ST_RUN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (run_last_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_DONE: begin
        state_n = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_OUT;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State register and the status flags that decode it. The flags are
  // registered from state_n so that they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      in_ready_r <= (state_n == ST_IDLE);
      busy_r     <= (state_n != ST_IDLE);
    end
  end

  // Datapath: capture, shift-add steps, final sign fix-up and the output handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_r         <= {(2*WIDTH){1'b0}};
      mc_r        <= {(2*WIDTH){1'b0}};
      r_r         <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      neg_r       <= 1'b0;
      product_r   <= {(2*WIDTH){1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            p_r   <= {(2*WIDTH){1'b0}};
            mc_r  <= {{WIDTH{1'b0}}, abs_a_s};
            r_r   <= abs_b_s;
            cnt_r <= {CNT_W{1'b0}};
            neg_r <= neg_s;
          end
        end
        ST_RUN: begin
          if (r_r[0]) begin
            p_r <= p_r + mc_r;
          end
          mc_r  <= {mc_r[2*WIDTH-2:0], 1'b0};
          r_r   <= {1'b0, r_r[WIDTH-1:1]};
          cnt_r <= cnt_r + CNT_W'(1);
        end
        ST_DONE: begin
          product_r   <= neg_r ? negate_2w(p_r) : p_r;
          out_valid_r <= 1'b1;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign product   = product_r;

endmodule

// File: tb/tb_seq_muln.sv
// tb_seq_muln -- self-checking bench for seq_muln.
// Three instances share clk and reset:
//   0: WIDTH=32, EARLY_TERM=1
//   1: WIDTH=32, EARLY_TERM=0
//   2: WIDTH=8,  EARLY_TERM=1
// The expected products and latencies come from directed constants and from an
// arithmetic reference model.
module tb_seq_muln;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_v [3];
  logic        in_ready_v [3];
  logic [1:0]  mode_v     [3];
  logic [31:0] a_v        [3];
  logic [31:0] b_v        [3];
  logic        out_valid_v[3];
  logic        out_ready_v[3];
  logic        busy_v     [3];
  logic [63:0] prod_a;
  logic [63:0] prod_b;
  logic [15:0] prod_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_muln #(.WIDTH(32), .EARLY_TERM(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .mode(mode_v[0]), .op_a(a_v[0]), .op_b(b_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .product(prod_a), .busy(busy_v[0]));

  seq_muln #(.WIDTH(32), .EARLY_TERM(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .mode(mode_v[1]), .op_a(a_v[1]), .op_b(b_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .product(prod_b), .busy(busy_v[1]));

  seq_muln #(.WIDTH(8), .EARLY_TERM(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .mode(mode_v[2]), .op_a(a_v[2][7:0]), .op_b(b_v[2][7:0]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .product(prod_c), .busy(busy_v[2]));

  typedef struct {
    int          idx;
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_p;
    int          exp_l;
    string       name;
  } vec_t;

  vec_t tbl[11];

  function automatic int width_of(input int idx);
    return (idx == 2) ? 8 : 32;
  endfunction

  function automatic logic [63:0] get_prod(input int idx);
    logic [63:0] r;
    case (idx)
      0:       r = prod_a;
      1:       r = prod_b;
      default: r = {48'h0, prod_c};
    endcase
    return r;
  endfunction

  // Reference: interpret the operands as integers and multiply.
  function automatic logic [63:0] ref_prod(input int idx, input logic [1:0] m,
                                           input logic [31:0] a, input logic [31:0] b);
    int     w;
    longint av;
    longint bv;
    logic [63:0] r;
    w  = width_of(idx);
    av = (w == 8) ? longint'(a[7:0]) : longint'(a);
    bv = (w == 8) ? longint'(b[7:0]) : longint'(b);
    if ((m == 2'd1 || m == 2'd2) && a[w-1]) av = av - (longint'(1) << w);
    if (m == 2'd1 && b[w-1]) bv = bv - (longint'(1) << w);
    r = 64'(av * bv);
    if (w == 8) r = r & 64'h0000_0000_0000_FFFF;
    return r;
  endfunction

  // Reference latency: one DONE cycle after the steps. Without early termination
  // there are always WIDTH steps. With it, the step count is the bit length of
  // |b|, with a minimum of one step.
  function automatic int ref_lat(input int idx, input logic [1:0] m, input logic [31:0] b);
    int     w;
    int     steps;
    longint mag;
    w   = width_of(idx);
    mag = (w == 8) ? longint'(b[7:0]) : longint'(b);
    if (m == 2'd1 && b[w-1]) mag = (longint'(1) << w) - mag;
    if (idx == 1) return w + 1;
    steps = 1;
    for (int i = 0; i < w; i++) begin
      if (((mag >> i) & 64'd1) != 0) steps = i + 1;
    end
    return steps + 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request. The task returns on the negedge after the accept edge.
  // The operands are then scrambled to show that the captured values are used.
  task automatic start_op(input int idx, input logic [1:0] m,
                          input logic [31:0] a, input logic [31:0] b, input string name);
    int t;
    t = 0;
    while (!in_ready_v[idx] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready_v[idx]) chk({name, " in_ready timeout"}, 64'(in_ready_v[idx]), 64'd1);
    in_valid_v[idx] = 1'b1;
    mode_v[idx]     = m;
    a_v[idx]        = a;
    b_v[idx]        = b;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[idx] = 1'b0;
    mode_v[idx]     = 2'($urandom_range(0, 3));
    a_v[idx]        = $urandom;
    b_v[idx]        = $urandom;
  endtask

  // Count the edges from the accept edge until out_valid is first seen.
  task automatic wait_out(input int idx, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid_v[idx] && lat < 200);
  endtask

  task automatic handoff(input int idx, input logic [63:0] exp_p, input string name);
    out_ready_v[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_v[idx] = 1'b0;
    chk({name, " out_valid after handoff"}, 64'(out_valid_v[idx]), 64'd0);
    chk({name, " in_ready after handoff"}, 64'(in_ready_v[idx]), 64'd1);
    chk({name, " product retained"}, get_prod(idx), exp_p);
  endtask

  task automatic run_vec(input int idx, input logic [1:0] m, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_p,
                         input int exp_l, input string name);
    int lat;
    start_op(idx, m, a, b, name);
    wait_out(idx, lat);
    chk({name, " latency"}, 64'(lat), 64'(exp_l));
    chk({name, " product"}, get_prod(idx), exp_p);
    handoff(idx, exp_p, name);
  endtask

  initial begin
    logic [63:0] exp_p;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rm;
    int          idx;
    int          lat;

    tbl[0]  = '{0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 2,  "ss_m1_m1"};
    tbl[1]  = '{0, 2'd1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, "ss_min_min"};
    tbl[2]  = '{1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, "uu_max_fixed"};
    tbl[3]  = '{0, 2'd2, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 3,  "su_m2_x3"};
    tbl[4]  = '{0, 2'd3, 32'hFFFF_FFFE, 32'h0000_0003, 64'h0000_0002_FFFF_FFFA, 3,  "mode11_as_uu"};
    tbl[5]  = '{0, 2'd0, 32'h0000_0007, 32'h0000_0001, 64'h0000_0000_0000_0007, 2,  "et_b1"};
    tbl[6]  = '{0, 2'd0, 32'h0000_007B, 32'h0000_0000, 64'h0000_0000_0000_0000, 2,  "et_b0"};
    tbl[7]  = '{0, 2'd0, 32'h0000_0005, 32'h0001_0000, 64'h0000_0000_0005_0000, 18, "et_b_bit16"};
    tbl[8]  = '{2, 2'd1, 32'h0000_0080, 32'h0000_0080, 64'h0000_0000_0000_4000, 9,  "w8_ss_min_min"};
    tbl[9]  = '{2, 2'd1, 32'h0000_00FF, 32'h0000_0002, 64'h0000_0000_0000_FFFE, 3,  "w8_ss_m1_x2"};
    tbl[10] = '{1, 2'd0, 32'h0000_0007, 32'h0000_0001, 64'h0000_0000_0000_0007, 33, "fixed_b1"};

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i]  = 1'b0;
      out_ready_v[i] = 1'b0;
      mode_v[i]      = 2'd0;
      a_v[i]         = 32'd0;
      b_v[i]         = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset in_ready", 64'(in_ready_v[i]), 64'd1);
      chk("reset out_valid", 64'(out_valid_v[i]), 64'd0);
      chk("reset busy", 64'(busy_v[i]), 64'd0);
      chk("reset product", get_prod(i), 64'd0);
    end
    reset = 1'b0;

    // The first table entry is accepted on the first edge after reset is released.
    for (int i = 0; i < 11; i++) begin
      run_vec(tbl[i].idx, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].exp_p, tbl[i].exp_l, tbl[i].name);
    end

    // Backpressure: hold the result for five cycles while a new request is offered.
    exp_p = 64'hFFFF_FFFF_FFFF_FFF1;
    start_op(0, 2'd1, 32'hFFFF_FFFD, 32'h0000_0005, "bp");
    wait_out(0, lat);
    chk("bp latency", 64'(lat), 64'd4);
    for (int c = 0; c < 5; c++) begin
      in_valid_v[0] = 1'b1;
      a_v[0]        = $urandom;
      b_v[0]        = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("bp out_valid held", 64'(out_valid_v[0]), 64'd1);
      chk("bp product held", prod_a, exp_p);
      chk("bp in_ready low", 64'(in_ready_v[0]), 64'd0);
      chk("bp busy", 64'(busy_v[0]), 64'd1);
    end
    in_valid_v[0] = 1'b0;
    handoff(0, exp_p, "bp");
    chk("bp busy after handoff", 64'(busy_v[0]), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("bp no stale accept", 64'(busy_v[0]), 64'd0);

    // Reset in the middle of RUN discards the operation in flight.
    start_op(0, 2'd0, 32'h1234_5678, 32'hFFFF_FFFF, "rst_mid");
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("rst_mid busy before", 64'(busy_v[0]), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid in_ready", 64'(in_ready_v[0]), 64'd1);
    chk("rst_mid out_valid", 64'(out_valid_v[0]), 64'd0);
    chk("rst_mid busy", 64'(busy_v[0]), 64'd0);
    chk("rst_mid product", prod_a, 64'd0);
    run_vec(0, 2'd1, 32'hFFFF_FFF9, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6, 4, "after_rst");

    // Randomized operands checked against the arithmetic model.
    for (int i = 0; i < 36; i++) begin
      idx = i % 3;
      rm  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      if (idx == 2) begin
        ra = ra & 32'h0000_00FF;
        rb = rb & 32'h0000_00FF;
      end
      run_vec(idx, rm, ra, rb, ref_prod(idx, rm, ra, rb), ref_lat(idx, rm, rb), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_muln.md
SEQ_MULN -- requirements
Module: seq_muln

Interface
REQ-001 Parameter WIDTH, default 32: operand width; legal values 4..64.
REQ-002 Parameter EARLY_TERM, default 1: 1 enables early termination, 0 forces a fixed WIDTH run steps.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand request.
REQ-006 in_ready  output  1  block accepts a request; high only in IDLE.
REQ-007 mode  input  2  00 unsigned x unsigned, 01 signed x signed, 10 signed a x unsigned b, 11 treated as 00.
REQ-008 op_a, op_b  input  WIDTH each  multiplicand and multiplier.
REQ-009 out_valid  output  1  product valid; held until out_ready.
REQ-010 out_ready  input  1  consumer accepts the product.
REQ-011 product  output  2*WIDTH  full-width two's-complement or unsigned result.
REQ-012 busy  output  1  high in RUN, DONE and OUT.

Function
REQ-013 States SHALL be IDLE, RUN, DONE and OUT; encodings come from the package.
REQ-014 IDLE: in_valid & in_ready at edge k SHALL capture the operands and enter RUN.
  - Capture: magnitude |a| when a is signed, magnitude |b| when b is signed, and neg = sign(a) XOR sign(b) over the signed operands only.
  - Clear: accumulator P (2W), step counter.
REQ-015 Magnitude of the most-negative value SHALL be 2^(WIDTH-1), held unsigned in WIDTH bits, with no overflow flag.
REQ-016 Each RUN cycle SHALL do the following.
  - If R[0] is set, add shifted multiplicand MC (2W) to P; carries beyond 2W are discarded.
  - Shift MC left by 1 and R right by 1.
  - Increment the counter.
REQ-017 RUN exit: leave for DONE after the step in which counter == WIDTH-1, or, if EARLY_TERM=1, when (R>>1) == 0.
  - Step count = WIDTH, or max(1, msb_index(|b|)+1).
REQ-018 DONE (one cycle): product <= neg ? (~P + 1) : P, out_valid <= 1, go to OUT.
REQ-019 Latency: out_valid SHALL first be visible after edge k+steps+1; with EARLY_TERM=0 that is k+WIDTH+1.
REQ-020 OUT: product and out_valid SHALL hold stable while out_ready is low.
  - out_valid & out_ready at an edge: clear out_valid, return to IDLE.
  - in_ready rises the following cycle; there is no accept overlap with OUT.
REQ-021 in_valid while not in IDLE SHALL be ignored; operand changes after capture SHALL not affect the result.
REQ-022 product SHALL retain the last result after handoff until the next DONE.

Reset
REQ-023 reset SHALL take priority over all other inputs, including mid-RUN and in OUT; the in-flight operation is discarded.
  - Values after reset: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, P/MC/R/counter/neg=0.
REQ-024 The first accept SHALL be possible in the cycle after reset deasserts.

Structure
REQ-025 Package seq_mul_pkg SHALL hold the mode encodings (MODE_UU, MODE_SS, MODE_SU) and the state encodings.
REQ-026 The block SHALL be a single module with no sub-modules; abs/negate are local functions sized by WIDTH.

Verification (WIDTH=32 unless stated)
REQ-027 SS: -1 x -1 -> product 0x0000000000000001; SS: 0x80000000 x 0x80000000 -> 0x4000000000000000.
REQ-028 UU: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE00000001 with EARLY_TERM=0, out_valid after edge k+33.
REQ-029 SU: a=0xFFFFFFFE (-2), b=3 -> 0xFFFFFFFFFFFFFFFA.
  - Mode 11 with the same operands -> 0x00000002FFFFFFFA.
REQ-030 Early termination.
  - b=1, a=7 -> 0x7, out_valid after edge k+2.
  - b=0 -> 0, out_valid after edge k+2.
  - b=0x00010000 -> out_valid after edge k+18.
REQ-031 Backpressure: hold out_ready low 5 cycles -> product and out_valid stable, in_ready=0, new in_valid ignored; ready then -> IDLE next cycle.
REQ-032 Reset mid-RUN at step 10 -> all outputs at reset values next cycle; a following request computes correctly.
  - Repeat REQ-027 with WIDTH=8: 0x80 x 0x80 -> 0x4000.
